// File: rtl/packet_output_arbiter.sv
// Packet-granular round-robin merge of C_NUM_INPUTS AXI-Stream inputs onto one registered output (1-cycle latency, 1 arbitration cycle per packet).
// Define PKT_OUTPUT_ARB_COUNTERS_EN to build the per-port forwarded-packet counters; otherwise pkt_cnt is tied to 0.
module packet_output_arbiter #(
    parameter int C_NUM_INPUTS         = 4,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_M_AXIS_TUSER_WIDTH = 128
) (
    input  logic                                            s_axi_aclk,
    input  logic                                            s_axi_aresetn,
    input  logic [C_NUM_INPUTS*C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_NUM_INPUTS*(C_S_AXIS_DATA_WIDTH/8)-1:0] s_axis_tstrb,
    input  logic [C_NUM_INPUTS*C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic [C_NUM_INPUTS-1:0]                         s_axis_tvalid,
    input  logic [C_NUM_INPUTS-1:0]                         s_axis_tlast,
    output logic [C_NUM_INPUTS-1:0]                         s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]                  m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]                m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]                 m_axis_tuser,
    output logic                                            m_axis_tvalid,
    output logic                                            m_axis_tlast,
    input  logic                                            m_axis_tready,
    input  logic                                            arb_en,
    output logic [2:0]                                      grant_idx,
    output logic [C_NUM_INPUTS*32-1:0]                      pkt_cnt
);

    localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int MW = C_M_AXIS_DATA_WIDTH / 8;

    typedef enum logic {IDLE, XFER} state_t;

    state_t                          state_q;
    logic [2:0]                      grant_q;
    logic [2:0]                      rr_ptr_q;
    logic                            m_vld_q;
    logic                            m_last_q;
    logic [C_M_AXIS_DATA_WIDTH-1:0]  m_dat_q;
    logic [MW-1:0]                   m_strb_q;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] m_user_q;

    logic                            slot_free;
    logic                            acc;
    logic                            acc_last;
    logic [C_NUM_INPUTS-1:0]         rdy;
    logic                            sel_vld;
    logic [2:0]                      sel_idx;
    logic [3:0]                      cand;
    logic [C_S_AXIS_DATA_WIDTH-1:0]  mux_dat;
    logic [SW-1:0]                   mux_strb;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] mux_user;

    // The output register can take a beat when empty or draining this cycle.
    assign slot_free = !m_vld_q || m_axis_tready;

    always_comb begin
        rdy      = '0;
        mux_dat  = '0;
        mux_strb = '0;
        mux_user = '0;
        for (int i = 0; i < C_NUM_INPUTS; i++) begin
            rdy[i] = (state_q == XFER) && (grant_q == 3'(i)) && slot_free;
            if (grant_q == 3'(i)) begin
                mux_dat  = s_axis_tdata[i*C_S_AXIS_DATA_WIDTH +: C_S_AXIS_DATA_WIDTH];
                mux_strb = s_axis_tstrb[i*SW +: SW];
                mux_user = s_axis_tuser[i*C_S_AXIS_TUSER_WIDTH +: C_S_AXIS_TUSER_WIDTH];
            end
        end
    end

    assign s_axis_tready = rdy;
    assign acc           = |(s_axis_tvalid & rdy);
    assign acc_last      = |(s_axis_tvalid & rdy & s_axis_tlast);

    // First valid port at or after rr_ptr, wrapping modulo C_NUM_INPUTS.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = 0; k < C_NUM_INPUTS; k++) begin
            cand = 4'(rr_ptr_q) + 4'(k);
            if (cand >= 4'(C_NUM_INPUTS)) cand = cand - 4'(C_NUM_INPUTS);
            for (int i = 0; i < C_NUM_INPUTS; i++) begin
                if (!sel_vld && cand == 4'(i) && s_axis_tvalid[i]) begin
                    sel_vld = 1'b1;
                    sel_idx = 3'(i);
                end
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            m_vld_q  <= 1'b0;
            m_last_q <= 1'b0;
            m_dat_q  <= '0;
            m_strb_q <= '0;
            m_user_q <= '0;
        end else begin
            if (acc) begin
                m_vld_q  <= 1'b1;
                m_dat_q  <= mux_dat;
                m_strb_q <= mux_strb;
                m_user_q <= mux_user;
                m_last_q <= acc_last;
            end else if (m_axis_tready) begin
                m_vld_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (arb_en && sel_vld) begin
                        grant_q <= sel_idx;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (acc_last) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= (grant_q == 3'(C_NUM_INPUTS-1)) ? 3'd0 : grant_q + 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tdata  = m_dat_q;
    assign m_axis_tstrb  = m_strb_q;
    assign m_axis_tuser  = m_user_q;
    assign grant_idx     = grant_q;

`ifdef PKT_OUTPUT_ARB_COUNTERS_EN
    logic [31:0] cnt_q [C_NUM_INPUTS];

    always_ff @(posedge s_axi_aclk) begin
        for (int i = 0; i < C_NUM_INPUTS; i++) begin
            if (!s_axi_aresetn) begin
                cnt_q[i] <= '0;
            end else if (acc_last && grant_q == 3'(i)) begin
                cnt_q[i] <= cnt_q[i] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < C_NUM_INPUTS; g++) begin : g_cnt
        assign pkt_cnt[g*32 +: 32] = cnt_q[g];
    end
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_packet_output_arbiter.sv
// Randomized bench for packet_output_arbiter against a packet-level round-robin reference model.
module tb_packet_output_arbiter;
    localparam int N  = 4;
    localparam int W  = 256;
    localparam int SW = 32;
    localparam int UW = 128;

    typedef struct packed {
        logic [W-1:0]  dat;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*W-1:0]  s_tdata = '0;
    logic [N*SW-1:0] s_tstrb = '0;
    logic [N*UW-1:0] s_tuser = '0;
    logic [N-1:0]    s_tvalid = '0;
    logic [N-1:0]    s_tlast = '0;
    logic [N-1:0]    s_tready;
    logic [W-1:0]    m_tdata;
    logic [SW-1:0]   m_tstrb;
    logic [UW-1:0]   m_tuser;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready = 1'b1;
    logic            arb_en = 1'b1;
    logic [2:0]      grant_idx;
    logic [N*32-1:0] pkt_cnt;

    always #5 clk = ~clk;

    packet_output_arbiter #(.C_NUM_INPUTS(N)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .arb_en(arb_en), .grant_idx(grant_idx), .pkt_cnt(pkt_cnt)
    );

    beat_t    stim [N][32];
    int       stim_len [N];
    int       stim_rd [N];
    int       sched [N];
    int       model_cnt [N];
    logic [N-1:0] hold;
    beat_t    exp_q [$];
    beat_t    obs_q [$];
    int       model_rr, errors, checks, acc_total;
    int       span_first, span_last, hold_viol, rdy_viol;
    int       rdy_pct, drop_pct, stall_beat, arb_off_after;
    logic     held_prev;
    beat_t    held_beat;

    function automatic void clear_stim();
        for (int p = 0; p < N; p++) begin
            stim_len[p] = 0; stim_rd[p] = 0; sched[p] = 0;
        end
        exp_q.delete(); obs_q.delete();
        acc_total = 0; span_first = -1; span_last = -1; hold_viol = 0; rdy_viol = 0;
        stall_beat = -1; arb_off_after = -1; hold = '0; held_prev = 1'b0;
        rdy_pct = 100; drop_pct = 0;
    endfunction

    function automatic void add_pkt(input int p, input int n);
        beat_t bt;
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < W/32; i++) bt.dat[i*32 +: 32] = $urandom();
            for (int i = 0; i < UW/32; i++) bt.user[i*32 +: 32] = $urandom();
            bt.strb = $urandom();
            bt.last = (b == n-1);
            stim[p][stim_len[p]] = bt;
            stim_len[p]++;
        end
    endfunction

    // Reference: whole packets leave in round-robin order over ports with work pending.
    function automatic void build_expected();
        int    found, p;
        beat_t bt;
        do begin
            found = -1;
            for (int k = 0; k < N; k++) begin
                p = (model_rr + k) % N;
                if (found < 0 && sched[p] < stim_len[p]) found = p;
            end
            if (found >= 0) begin
                do begin
                    bt = stim[found][sched[found]];
                    exp_q.push_back(bt);
                    sched[found]++;
                end while (!bt.last && sched[found] < stim_len[found]);
                model_cnt[found]++;
                model_rr = (found + 1) % N;
            end
        end while (found >= 0);
    endfunction

    task automatic run_traffic(input int target, input int max_cyc, output bit timed_out);
        int    cyc, stall_left;
        bit    stall_done;
        beat_t bt, cur;
        cyc = 0; stall_left = 0; stall_done = 0; timed_out = 0;
        while (obs_q.size() < target && !timed_out) begin
            @(posedge clk); #1;
            if (arb_off_after >= 0 && acc_total >= arb_off_after) arb_en = 1'b0;
            for (int p = 0; p < N; p++) begin
                if (stim_rd[p] < stim_len[p]) begin
                    bt = stim[p][stim_rd[p]];
                    s_tdata[p*W +: W]   = bt.dat;
                    s_tstrb[p*SW +: SW] = bt.strb;
                    s_tuser[p*UW +: UW] = bt.user;
                    s_tlast[p]          = bt.last;
                    if (hold[p]) s_tvalid[p] = 1'b1;
                    else if (stim_rd[p] == 0 || stim[p][stim_rd[p]-1].last) s_tvalid[p] = 1'b1;
                    else s_tvalid[p] = ($urandom_range(99) >= drop_pct);
                end else begin
                    s_tvalid[p] = 1'b0;
                end
            end
            if (stall_left > 0) begin
                m_tready = 1'b0; stall_left--;
            end else if (stall_beat >= 0 && !stall_done && m_tvalid && obs_q.size() == stall_beat-1) begin
                m_tready = 1'b0; stall_left = 3; stall_done = 1;
            end else begin
                m_tready = ($urandom_range(99) < rdy_pct);
            end
            @(negedge clk);
            cyc++;
            cur = {m_tdata, m_tstrb, m_tuser, m_tlast};
            if (m_tvalid) begin
                if (span_first < 0) span_first = cyc;
                span_last = cyc;
            end
            if (held_prev && (!m_tvalid || cur !== held_beat)) hold_viol++;
            held_prev = m_tvalid && !m_tready;
            held_beat = cur;
            if (s_tready != '0 && (s_tready != (N'(1) << grant_idx) || (m_tvalid && !m_tready))) rdy_viol++;
            if (m_tvalid && m_tready) obs_q.push_back(cur);
            for (int p = 0; p < N; p++) begin
                if (s_tvalid[p] && s_tready[p]) begin
                    stim_rd[p]++; acc_total++;
                end
            end
            hold = s_tvalid & ~s_tready;
            if (cyc >= max_cyc) timed_out = 1;
        end
        @(posedge clk); #1;
        s_tvalid = '0; hold = '0; held_prev = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; arb_en = 1'b1; m_tready = 1'b1; s_tvalid = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_mvalid: got %b want 0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_mlast: got %b want 0", m_tlast); end
        checks++; if ({m_tdata, m_tstrb, m_tuser} !== '0) begin errors++; $display("FAIL reset_mdata: got %h want 0", m_tdata[31:0]); end
        checks++; if (s_tready !== '0) begin errors++; $display("FAIL reset_sready: got %b want 0", s_tready); end
        checks++; if (grant_idx !== 3'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant_idx); end
        checks++; if (pkt_cnt !== '0) begin errors++; $display("FAIL reset_pktcnt: got %h want 0", pkt_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1; s_tvalid = '0;
        model_rr = 0;
        foreach (model_cnt[p]) model_cnt[p] = 0;
    endtask

    task automatic test_rr_order();
        bit to;
        clear_stim();
        for (int p = 0; p < N; p++) add_pkt(p, 3);
        build_expected();
        run_traffic(12, 300, to);
        checks++; if (to) begin errors++; $display("FAIL rr_order_timeout: got %0d beats want 12", obs_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rr_order beat %0d: got %h/%b want %h/%b", i, obs_q[i].dat[31:0], obs_q[i].last, exp_q[i].dat[31:0], exp_q[i].last);
            end
        end
        checks++; if (span_last - span_first + 1 != 15) begin errors++; $display("FAIL rr_order_span: got %0d want 15", span_last - span_first + 1); end
        checks++; if (rdy_viol != 0) begin errors++; $display("FAIL rr_order_tready: got %0d bad cycles want 0", rdy_viol); end
    endtask

    task automatic test_backpressure();
        bit to;
        clear_stim();
        add_pkt(2, 5);
        build_expected();
        stall_beat = 3;
        run_traffic(5, 200, to);
        checks++; if (to || obs_q.size() != 5) begin errors++; $display("FAIL bp_count: got %0d beats want 5", obs_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp beat %0d: got %h/%b want %h/%b", i, obs_q[i].dat[31:0], obs_q[i].last, exp_q[i].dat[31:0], exp_q[i].last);
            end
        end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_viol); end
    endtask

    task automatic test_rr_wrap();
        bit to;
        clear_stim();
        add_pkt(3, 2);
        build_expected();
        run_traffic(2, 100, to);
        checks++; if (to) begin errors++; $display("FAIL wrap_pre: got %0d beats want 2", obs_q.size()); end
        clear_stim();
        add_pkt(0, 2);
        add_pkt(3, 2);
        build_expected();
        run_traffic(4, 100, to);
        checks++; if (to || obs_q[0] !== stim[0][0]) begin errors++; $display("FAIL wrap_first: got %h want %h", obs_q[0].dat[31:0], stim[0][0].dat[31:0]); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL wrap beat %0d: got %h want %h", i, obs_q[i].dat[31:0], exp_q[i].dat[31:0]);
            end
        end
    endtask

    task automatic test_arb_en();
        bit to;
        clear_stim();
        add_pkt(1, 4);
        add_pkt(2, 2);
        build_expected();
        arb_off_after = 2;
        run_traffic(4, 100, to);
        checks++; if (to || obs_q.size() != 4) begin errors++; $display("FAIL arb_complete: got %0d beats want 4", obs_q.size()); end
        run_traffic(5, 20, to);
        checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL arb_blocked: got %0d beats want 4", obs_q.size()); end
        arb_en = 1'b1; arb_off_after = -1;
        run_traffic(6, 100, to);
        checks++; if (to) begin errors++; $display("FAIL arb_resume: got %0d beats want 6", obs_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL arb beat %0d: got %h want %h", i, obs_q[i].dat[31:0], exp_q[i].dat[31:0]);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        int n;
        for (int it = 0; it < 4; it++) begin
            clear_stim();
            rdy_pct  = $urandom_range(30, 100);
            drop_pct = $urandom_range(0, 50);
            for (int p = 0; p < N; p++) begin
                n = (p == it % N) ? $urandom_range(1, 3) : $urandom_range(0, 3);
                for (int j = 0; j < n; j++) add_pkt(p, $urandom_range(1, 6));
            end
            build_expected();
            run_traffic(exp_q.size(), 3000, to);
            checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout: got %0d want %0d beats", it, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rand%0d beat %0d: got %h/%b want %h/%b", it, i, obs_q[i].dat[31:0], obs_q[i].last, exp_q[i].dat[31:0], exp_q[i].last);
                end
            end
            checks++; if (hold_viol != 0) begin errors++; $display("FAIL rand%0d_hold: got %0d want 0", it, hold_viol); end
            checks++; if (rdy_viol != 0) begin errors++; $display("FAIL rand%0d_tready: got %0d want 0", it, rdy_viol); end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_stim();
        add_pkt(1, 2);
        build_expected();
        run_traffic(2, 100, to);
        clear_stim();
        add_pkt(2, 4);
        build_expected();
        run_traffic(2, 100, to);
        s_tvalid[2] = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_mvalid: got %b want 0", m_tvalid); end
        checks++; if (s_tready !== '0) begin errors++; $display("FAIL rstmid_sready: got %b want 0", s_tready); end
        checks++; if (pkt_cnt !== '0) begin errors++; $display("FAIL rstmid_pktcnt: got %h want 0", pkt_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1; s_tvalid = '0;
        model_rr = 0;
        foreach (model_cnt[p]) model_cnt[p] = 0;
        clear_stim();
        add_pkt(3, 2);
        add_pkt(0, 2);
        build_expected();
        run_traffic(4, 100, to);
        checks++; if (to || obs_q[0] !== stim[0][0]) begin errors++; $display("FAIL rstmid_rrptr: got %h want %h", obs_q[0].dat[31:0], stim[0][0].dat[31:0]); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rstmid beat %0d: got %h want %h", i, obs_q[i].dat[31:0], exp_q[i].dat[31:0]);
            end
        end
    endtask

    task automatic test_counters();
        bit to;
        int exp_c;
        @(posedge clk); #1;
        rst_n = 1'b0; s_tvalid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_rr = 0;
        foreach (model_cnt[p]) model_cnt[p] = 0;
        clear_stim();
        for (int j = 0; j < 3; j++) add_pkt(1, $urandom_range(1, 4));
        build_expected();
        run_traffic(exp_q.size(), 200, to);
        checks++; if (to) begin errors++; $display("FAIL cnt_timeout: got %0d want %0d beats", obs_q.size(), exp_q.size()); end
        for (int p = 0; p < N; p++) begin
`ifdef PKT_OUTPUT_ARB_COUNTERS_EN
            exp_c = model_cnt[p];
`else
            exp_c = 0;
`endif
            checks++;
            if (pkt_cnt[p*32 +: 32] !== 32'(exp_c)) begin
                errors++; $display("FAIL cnt_port%0d: got %0d want %0d", p, pkt_cnt[p*32 +: 32], exp_c);
            end
        end
    endtask

    initial begin
        errors = 0; checks = 0; model_rr = 0;
        clear_stim();
        test_reset();
        test_rr_order();
        test_backpressure();
        test_rr_wrap();
        test_arb_en();
        test_random();
        test_reset_mid();
        test_counters();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/packet_output_arbiter.md
PACKET_OUTPUT_ARBITER -- requirements
Module: packet_output_arbiter

Interface
REQ-001 SHALL have parameter C_NUM_INPUTS, default 4, number of AXI-Stream slave ports (2..8).
REQ-002 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, slave tdata width; tstrb width = C_S_AXIS_DATA_WIDTH/8.
REQ-003 SHALL have parameter C_M_AXIS_DATA_WIDTH, default 256, master tdata width; must equal C_S_AXIS_DATA_WIDTH.
REQ-004 SHALL have parameters C_S_AXIS_TUSER_WIDTH and C_M_AXIS_TUSER_WIDTH, default 128 each, tuser widths; must be equal.
REQ-005 SHALL have port s_axi_aclk  input  1  single clock for all logic.
REQ-006 SHALL have port s_axi_aresetn  input  1  synchronous, active-low reset.
REQ-007 SHALL have port s_axis_tdata  input  C_NUM_INPUTS*256  flattened slave data; port i at slice [i*256 +: 256].
REQ-008 SHALL have port s_axis_tstrb  input  C_NUM_INPUTS*32  flattened slave byte strobes.
REQ-009 SHALL have port s_axis_tuser  input  C_NUM_INPUTS*128  flattened slave sideband (packet metadata).
REQ-010 SHALL have ports s_axis_tvalid / s_axis_tlast  input  C_NUM_INPUTS  one bit per slave port.
REQ-011 SHALL have port s_axis_tready  output  C_NUM_INPUTS  one bit per slave port.
REQ-012 SHALL have ports m_axis_tdata 256, m_axis_tstrb 32, m_axis_tuser 128, m_axis_tvalid 1, m_axis_tlast 1  output  merged master stream.
REQ-013 SHALL have port m_axis_tready  input  1  downstream backpressure.
REQ-014 SHALL have port arb_en  input  1  when high, new packet grants permitted.
REQ-015 SHALL have port grant_idx  output  3  index of currently granted port (valid in state XFER).
REQ-016 SHALL have port pkt_cnt  output  C_NUM_INPUTS*32  per-port forwarded-packet counters.

Function
REQ-017 SHALL implement FSM with states IDLE and XFER.
REQ-018 In IDLE with arb_en=1 and any s_axis_tvalid high, SHALL select the first valid port scanning rr_ptr, rr_ptr+1, ... modulo C_NUM_INPUTS, load grant_idx, enter XFER next cycle.
REQ-019 In IDLE, all s_axis_tready SHALL be 0; no beat is accepted in the arbitration cycle.
REQ-020 In XFER, only s_axis_tready[grant_idx] SHALL be asserted, equal to (!m_axis_tvalid || m_axis_tready); all others 0.
REQ-021 Master output SHALL be a single register stage: an accepted slave beat appears on m_axis_* exactly 1 cycle later; data/strb/user/last held stable while m_axis_tvalid && !m_axis_tready.
REQ-022 m_axis_tvalid SHALL clear after a master handshake unless a new beat is accepted in the same cycle (full throughput: 1 beat/cycle under no backpressure).
REQ-023 Acceptance of a slave beat with tlast=1 SHALL move FSM to IDLE next cycle and set rr_ptr = (grant_idx+1) mod C_NUM_INPUTS.
REQ-024 Grant SHALL be held for the whole packet; arb_en deassertion mid-packet SHALL NOT truncate it, only block the next grant.
REQ-025 Slave tvalid dropping mid-packet SHALL stall XFER with no grant change (no timeout).
REQ-026 Packet-to-packet gap SHALL be exactly 1 idle cycle on the slave side (arbitration cycle); master stream may remain continuous via register stage.
REQ-027 pkt_cnt[i] SHALL increment by 1 on each accepted tlast beat from port i, wrapping 2^32-1 -> 0.

Reset
REQ-028 On s_axi_aresetn=0 at a rising edge: FSM=IDLE, rr_ptr=0, grant_idx=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tstrb/tuser=0, s_axis_tready=0, pkt_cnt=0.
REQ-029 Reset mid-packet SHALL discard the in-flight beat and packet; downstream sees m_axis_tvalid=0 the cycle after reset asserts.

Configuration
REQ-030 Macro PKT_OUTPUT_ARB_COUNTERS_EN: defined -> pkt_cnt counters per REQ-027; undefined -> no counter registers, pkt_cnt driven constant 0.

Verification
REQ-031 Ports 0..3 each offer one 3-beat packet simultaneously, m_axis_tready=1 -> output order 0,1,2,3; each 3 beats contiguous; 1-cycle gap on slave side between packets.
REQ-032 Port 2 only, 5-beat packet, m_axis_tready low for 4 cycles on beat 3 -> beat 3 held stable, no loss/duplication, tlast only on beat 5.
REQ-033 After port 3 served, ports 0 and 3 both valid -> port 0 granted first (rr wrap).
REQ-034 arb_en dropped on beat 2 of 4-beat packet from port 1 -> packet completes; no further grant until arb_en=1.
REQ-035 Reset asserted on beat 2 of a packet -> next cycle m_axis_tvalid=0, all s_axis_tready=0, pkt_cnt=0, rr_ptr=0.
REQ-036 With PKT_OUTPUT_ARB_COUNTERS_EN, 3 packets from port 1 -> pkt_cnt[63:32]=3, others 0; without macro -> pkt_cnt=0.
